sha_512_pad: RTL and testbench

Message-to-block front end for the `sha_512` core. Accepts a message as a stream of 64-bit words and applies FIPS 180-4 SHA-512 padding: a 0x80 byte, zero fill, and a 128-bit big-endian bit length. Emits one 1024-bit block at a time on the core's `Data`/`Index`/`Operation`/`Enable` inputs and waits for the core's `Ready` before presenting the next block. Sits directly upstream of the core; the core's `Hash` output is not routed through this block.

---
 rtl/sha_512_pad.sv | 239 +++++++++++++++++++++++
 tb/tb_sha_512_pad.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_512_pad.sv
// sha_512_pad: message-to-block front end for the sha_512 core.
//
// Takes a message as a stream of 64-bit words and applies SHA-512 padding:
// a 0x80 byte, zero fill and a 128-bit big-endian bit length. The result
// goes to the core one 1024-bit block at a time. The next block is held
// back until the core reports Ready.
//
// Build option:
//   SHA_512_PAD_BYTES_EN  when defined, In_Bytes (0..8, left-aligned) gives
//                         the valid byte count of the In_Last word. When
//                         undefined, every word carries 8 bytes.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   In_Data       message word, first byte in [63:56]
//   In_Bytes      valid bytes on the last word (values above 8 act as 8)
//   In_Valid      word present
//   In_Last       final word of the message
//   In_Ready      word accepted when In_Valid & In_Ready
//   In_Op         hash mode, sampled with the first word
//   Data          block to core, word i at [64*i+63:64*i]
//   Index         block number within the message
//   Operation     latched In_Op
//   Enable        one-cycle start pulse to the core
//   Core_Ready    core finished the current block
//   Done          one-cycle pulse when the final block has been hashed
module sha_512_pad #(
    parameter int LEN_W = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   In_Data,
    input  logic [3:0]    In_Bytes,
    input  logic          In_Valid,
    input  logic          In_Last,
    output logic          In_Ready,
    input  logic [1:0]    In_Op,
    output logic [1023:0] Data,
    output logic [127:0]  Index,
    output logic [1:0]    Operation,
    output logic          Enable,
    input  logic          Core_Ready,
    output logic          Done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        PAD  = 3'd2,
        SEND = 3'd3,
        WAIT = 3'd4
    } state_t;

    // What happens after the block currently in flight is hashed.
    typedef enum logic [1:0] {
        NEXT_FINAL = 2'd0,   // this block is the last one
        NEXT_MORE  = 2'd1,   // further message words follow
        NEXT_PAD   = 2'd2,   // message ended on a block boundary: 0x80 + length block
        NEXT_LEN   = 2'd3    // pad byte sent, length did not fit: length-only block
    } pending_t;

    state_t           state_reg;
    state_t           state_next;
    pending_t         pending_reg;
    logic [1023:0]    block_reg;
    logic [3:0]       wp_reg;
    logic [7:0]       pos_reg;     // byte offset of the 0x80 pad byte in the block
    logic [LEN_W-1:0] len_reg;
    logic [127:0]     index_reg;
    logic [1:0]       op_reg;

    logic             in_open;
    logic             accept;
    logic [3:0]       eff_bytes;
    logic [3:0]       wp_cur;
    logic             full_word;
    logic             whole_last;
    logic [7:0]       pos_cur;
    logic [LEN_W-1:0] len_add;
    logic [127:0]     len_field;
    logic [1023:0]    len_block;
    logic [1023:0]    pad_bytes;
    logic [1023:0]    pad_block;
    logic             fits_len;

`ifdef SHA_512_PAD_BYTES_EN
    // Only the last word may be partial; oversize counts saturate at 8.
    always_comb begin
        eff_bytes = 4'd8;
        if (In_Last && (In_Bytes < 4'd8)) begin
            eff_bytes = In_Bytes;
        end
    end
`else
    logic unused_bytes;
    assign unused_bytes = ^In_Bytes;
    assign eff_bytes    = 4'd8;
`endif

    assign in_open    = (state_reg == IDLE) || (state_reg == FILL);
    assign accept     = In_Valid && in_open;
    // The first word of a message always lands in buffer word 0.
    assign wp_cur     = (state_reg == IDLE) ? 4'd0 : wp_reg;
    assign full_word  = (wp_cur == 4'd15);
    assign whole_last = full_word && (eff_bytes == 4'd8);
    assign pos_cur    = {1'b0, wp_cur, 3'b000} + {4'b0000, eff_bytes};
    assign len_add    = LEN_W'({eff_bytes, 3'b000});
    assign len_field  = 128'(len_reg);
    // Word 14 carries the high half and word 15 the low half of the length.
    assign len_block  = {len_field[63:0], len_field[127:64], 896'd0};

    // Byte k of the block sits in word k/8, first byte in the word's MSBs.
    genvar gi;
    generate
        for (gi = 0; gi < 128; gi = gi + 1) begin : g_pad_byte
            localparam int LSB = 64 * (gi / 8) + 56 - 8 * (gi % 8);
            assign pad_bytes[LSB +: 8] = (pos_reg == 8'(gi)) ? 8'h80 :
                                         (pos_reg <  8'(gi)) ? 8'h00 :
                                                               block_reg[LSB +: 8];
        end
    endgenerate

    // The pad byte leaves room for the length when it lies at byte 111 or below.
    assign fits_len  = (pos_reg <= 8'd111);
    assign pad_block = fits_len ? {len_block[1023:896], pad_bytes[895:0]} : pad_bytes;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, FILL: begin
                if (accept) begin
                    if (In_Last) begin
                        state_next = whole_last ? SEND : PAD;
                    end else if (full_word) begin
                        state_next = SEND;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            PAD:  state_next = SEND;
            SEND: state_next = WAIT;
            WAIT: begin
                if (Core_Ready) begin
                    case (pending_reg)
                        NEXT_FINAL: state_next = IDLE;
                        NEXT_MORE:  state_next = FILL;
                        default:    state_next = SEND;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        In_Ready = in_open && !rst;
        Enable   = (state_reg == SEND);
        Done     = (state_reg == WAIT) && Core_Ready && (pending_reg == NEXT_FINAL);
    end

    assign Data      = block_reg;
    assign Index     = index_reg;
    assign Operation = op_reg;

    // Datapath: buffer, pointers, length and block bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block_reg   <= '0;
            wp_reg      <= '0;
            pos_reg     <= '0;
            len_reg     <= '0;
            index_reg   <= '0;
            op_reg      <= '0;
            pending_reg <= NEXT_FINAL;
        end else begin
            case (state_reg)
                IDLE, FILL: begin
                    if (accept) begin
                        if (state_reg == IDLE) begin
                            op_reg    <= In_Op;
                            index_reg <= '0;
                            block_reg <= {960'd0, In_Data};
                            len_reg   <= len_add;
                        end else begin
                            block_reg[{wp_reg, 6'b000000} +: 64] <= In_Data;
                            len_reg <= len_reg + len_add;
                        end
                        wp_reg  <= wp_cur + 4'd1;
                        pos_reg <= pos_cur;
                        if (In_Last) begin
                            // A non-boundary last word is resolved in PAD.
                            pending_reg <= whole_last ? NEXT_PAD : NEXT_FINAL;
                        end else begin
                            pending_reg <= NEXT_MORE;
                        end
                    end
                end
                PAD: begin
                    block_reg   <= pad_block;
                    pending_reg <= fits_len ? NEXT_FINAL : NEXT_LEN;
                end
                WAIT: begin
                    if (Core_Ready) begin
                        index_reg <= index_reg + 128'd1;
                        case (pending_reg)
                            NEXT_MORE: begin
                                block_reg <= '0;
                                wp_reg    <= '0;
                            end
                            NEXT_PAD: begin
                                block_reg   <= len_block | {960'd0, 64'h8000_0000_0000_0000};
                                pending_reg <= NEXT_FINAL;
                            end
                            NEXT_LEN: begin
                                block_reg   <= len_block;
                                pending_reg <= NEXT_FINAL;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_512_pad.sv
// tb_sha_512_pad: directed bench for sha_512_pad with a small core stand-in.
// Builds with or without SHA_512_PAD_BYTES_EN; partial-word vectors run only
// when it is defined.
module tb_sha_512_pad;

    localparam int CORE_LAT = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   In_Data = '0;
    logic [3:0]    In_Bytes = '0;
    logic          In_Valid = 1'b0;
    logic          In_Last = 1'b0;
    logic          In_Ready;
    logic [1:0]    In_Op = '0;
    logic [1023:0] Data;
    logic [127:0]  Index;
    logic [1:0]    Operation;
    logic          Enable;
    logic          Core_Ready = 1'b0;
    logic          Done;

    always #5 clk = ~clk;

    sha_512_pad #(.LEN_W(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .In_Data    (In_Data),
        .In_Bytes   (In_Bytes),
        .In_Valid   (In_Valid),
        .In_Last    (In_Last),
        .In_Ready   (In_Ready),
        .In_Op      (In_Op),
        .Data       (Data),
        .Index      (Index),
        .Operation  (Operation),
        .Enable     (Enable),
        .Core_Ready (Core_Ready),
        .Done       (Done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Core stand-in: records each started block, answers with Ready later.
    logic [1023:0] blk_q[$];
    logic [127:0]  idx_q[$];
    logic [1:0]    op_q[$];
    int            en_q[$];
    int            cr_q[$];
    int            core_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            core_cnt   = 0;
            Core_Ready = 1'b0;
        end else begin
            Core_Ready = 1'b0;
            if (Enable) begin
                blk_q.push_back(Data);
                idx_q.push_back(Index);
                op_q.push_back(Operation);
                en_q.push_back(cyc);
                core_cnt = CORE_LAT;
            end else if (core_cnt > 0) begin
                core_cnt = core_cnt - 1;
                if (core_cnt == 0) begin
                    Core_Ready = 1'b1;
                    cr_q.push_back(cyc);
                end
            end
        end
    end

    // Done counter and "In_Ready while a block is in flight" watcher.
    int   done_cnt = 0;
    int   rdy_bad  = 0;
    logic busy     = 1'b0;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            busy = 1'b0;
        end else begin
            if (busy && In_Ready) rdy_bad++;
            if (Enable) busy = 1'b1;
            if (Done) begin
                done_cnt++;
                busy = 1'b0;
            end
        end
    end

    function automatic logic [63:0] pat(input int k);
        return 64'h0101010101010101 * 64'(k + 1);
    endfunction

    int last_acc = 0;
    int done0    = 0;

    // Called at a negedge; returns at the negedge after the word is taken.
    task automatic put_word(input logic [63:0] d, input logic [3:0] b,
                            input logic last, input logic [1:0] op);
        int waited = 0;
        In_Data  = d;
        In_Bytes = b;
        In_Last  = last;
        In_Op    = op;
        In_Valid = 1'b1;
        while (!In_Ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", 128'(In_Ready), 128'(1));
        last_acc = cyc;
        @(negedge clk);
    endtask

    // Words pat(0..nw-1); In_Op changes after the first word to prove it is latched.
    task automatic send_pat(input int nw, input logic [3:0] lb, input logic [1:0] op,
                            input logic fin);
        for (int k = 0; k < nw; k++) begin
            put_word(pat(k), (k == nw - 1) ? lb : 4'd8, fin && (k == nw - 1),
                     (k == 0) ? op : ~op);
        end
        In_Valid = 1'b0;
        In_Last  = 1'b0;
    endtask

    task automatic start_msg();
        blk_q.delete();
        idx_q.delete();
        op_q.delete();
        en_q.delete();
        cr_q.delete();
        done0   = done_cnt;
        rdy_bad = 0;
    endtask

    task automatic finish_msg(input string tag, input int nblk);
        int waited = 0;
        while ((done_cnt == done0 || blk_q.size() < nblk) && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        repeat (CORE_LAT + 4) @(negedge clk);
        check({tag, "_blocks"}, 128'(blk_q.size()), 128'(nblk));
        check({tag, "_done"}, 128'(done_cnt - done0), 128'(1));
        $display("msg %s: blocks=%0d done_pulses=%0d", tag, blk_q.size(), done_cnt - done0);
    endtask

    task automatic check_blk(input string tag, input int b, input logic [1023:0] exp,
                             input logic [127:0] exp_idx, input logic [1:0] exp_op);
        if (blk_q.size() > b) begin
            for (int i = 0; i < 16; i++) begin
                check($sformatf("%s_b%0d_w%0d", tag, b, i),
                      128'(blk_q[b][64*i +: 64]), 128'(exp[64*i +: 64]));
            end
            check($sformatf("%s_b%0d_index", tag, b), idx_q[b], exp_idx);
            check($sformatf("%s_b%0d_op", tag, b), 128'(op_q[b]), 128'(exp_op));
        end
    endtask

    task automatic run_abc(input string tag);
        logic [1023:0] e = '0;
        start_msg();
        put_word(64'h6162630000000000, 4'd3, 1'b1, 2'd3);
        In_Valid = 1'b0;
        In_Last  = 1'b0;
        finish_msg(tag, 1);
`ifdef SHA_512_PAD_BYTES_EN
        e[63:0]      = 64'h6162638000000000;
        e[1023:960]  = 64'h18;
`else
        e[63:0]      = 64'h6162630000000000;
        e[127:64]    = 64'h8000000000000000;
        e[1023:960]  = 64'h40;
`endif
        check_blk(tag, 0, e, 128'd0, 2'd3);
        if (en_q.size() > 0) check({tag, "_lat"}, 128'(en_q[0] - last_acc), 128'(2));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] e;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", 128'(In_Ready), 128'(0));
        check("rst_enable", 128'(Enable), 128'(0));
        check("rst_done", 128'(Done), 128'(0));
        check("rst_index", Index, 128'(0));
        check("rst_op", 128'(Operation), 128'(0));
        for (int i = 0; i < 16; i++) check($sformatf("rst_data_w%0d", i), 128'(Data[64*i +: 64]), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 128'(In_Ready), 128'(1));

        run_abc("abc");

`ifdef SHA_512_PAD_BYTES_EN
        // Empty message
        start_msg();
        put_word(64'hDEADBEEFCAFEF00D, 4'd0, 1'b1, 2'd0);
        In_Valid = 1'b0;
        In_Last  = 1'b0;
        finish_msg("empty", 1);
        e = '0;
        e[63:0] = 64'h8000000000000000;
        check_blk("empty", 0, e, 128'd0, 2'd0);

        // 111 bytes: last word has 7 bytes, length still fits
        start_msg();
        send_pat(14, 4'd7, 2'd1, 1'b1);
        finish_msg("m111", 1);
        e = '0;
        for (int k = 0; k < 13; k++) e[64*k +: 64] = pat(k);
        e[64*13 +: 64] = 64'h0E0E0E0E0E0E0E80;
        e[1023:960]    = 64'h378;
        check_blk("m111", 0, e, 128'd0, 2'd1);
`endif

        // 112 bytes: pad byte in word 14, length spills into a second block
        start_msg();
        send_pat(14, 4'd8, 2'd1, 1'b1);
        finish_msg("m112", 2);
        e = '0;
        for (int k = 0; k < 14; k++) e[64*k +: 64] = pat(k);
        e[64*14 +: 64] = 64'h8000000000000000;
        check_blk("m112", 0, e, 128'd0, 2'd1);
        e = '0;
        e[1023:960] = 64'h380;
        check_blk("m112", 1, e, 128'd1, 2'd1);
        if (en_q.size() > 0) check("m112_lat0", 128'(en_q[0] - last_acc), 128'(2));
        if (en_q.size() > 1 && cr_q.size() > 0) check("m112_lat1", 128'(en_q[1] - cr_q[0]), 128'(1));

        // 128 bytes: boundary message, pad + length in a second block
        start_msg();
        send_pat(16, 4'd8, 2'd2, 1'b1);
        finish_msg("m128", 2);
        e = '0;
        for (int k = 0; k < 16; k++) e[64*k +: 64] = pat(k);
        check_blk("m128", 0, e, 128'd0, 2'd2);
        e = '0;
        e[63:0]     = 64'h8000000000000000;
        e[1023:960] = 64'h400;
        check_blk("m128", 1, e, 128'd1, 2'd2);
        if (en_q.size() > 0) check("m128_lat0", 128'(en_q[0] - last_acc), 128'(1));
        if (en_q.size() > 1 && cr_q.size() > 0) check("m128_lat1", 128'(en_q[1] - cr_q[0]), 128'(1));
        check("m128_in_ready_busy", 128'(rdy_bad), 128'(0));

        // 136 bytes: more-message path, input reopens the cycle after Ready
        start_msg();
        send_pat(17, 4'd8, 2'd3, 1'b1);
        finish_msg("m136", 2);
        e = '0;
        for (int k = 0; k < 16; k++) e[64*k +: 64] = pat(k);
        check_blk("m136", 0, e, 128'd0, 2'd3);
        e = '0;
        e[63:0]     = pat(16);
        e[127:64]   = 64'h8000000000000000;
        e[1023:960] = 64'h440;
        check_blk("m136", 1, e, 128'd1, 2'd3);
        if (cr_q.size() > 0) check("m136_reopen", 128'(last_acc - cr_q[0]), 128'(1));
        if (en_q.size() > 1) check("m136_lat1", 128'(en_q[1] - last_acc), 128'(2));

        // Reset while the core is working on block 0 of a longer message
        start_msg();
        send_pat(16, 4'd8, 2'd3, 1'b0);
        begin
            int waited = 0;
            while (blk_q.size() < 1 && waited < 2000) begin
                @(negedge clk);
                waited++;
            end
        end
        check("mrst_block0_seen", 128'(blk_q.size()), 128'(1));
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mrst_in_ready", 128'(In_Ready), 128'(0));
        check("mrst_enable", 128'(Enable), 128'(0));
        check("mrst_done", 128'(Done), 128'(0));
        check("mrst_index", Index, 128'(0));
        check("mrst_op", 128'(Operation), 128'(0));
        for (int i = 0; i < 16; i++) check($sformatf("mrst_data_w%0d", i), 128'(Data[64*i +: 64]), 128'(0));
        $display("msg mrst: reset applied during WAIT");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_in_ready_after", 128'(In_Ready), 128'(1));

        run_abc("abc_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
